// File: rtl/control_reloj_if.sv
// control_reloj_if
// Groups the button inputs and the timing/mode outputs of control_reloj.
//   btn_modo, btn_ajuste : raw push-buttons (asynchronous, active-high)
//   tick_seg             : one-cycle seconds advance pulse
//   inc_min, inc_hora    : one-cycle increment pulses for the time counter
//   clr_seg              : one-cycle seconds clear pulse
//   modo                 : 00 RUN, 01 SET_HORAS, 10 SET_MIN
//   parpadeo             : display blink enable, 1 = digits visible
// master: board / test side.  slave: the controller.
interface control_reloj_if;
    logic       btn_modo;
    logic       btn_ajuste;
    logic       tick_seg;
    logic       inc_min;
    logic       inc_hora;
    logic       clr_seg;
    logic [1:0] modo;
    logic       parpadeo;

    modport master (
        output btn_modo, btn_ajuste,
        input  tick_seg, inc_min, inc_hora, clr_seg, modo, parpadeo
    );

    modport slave (
        input  btn_modo, btn_ajuste,
        output tick_seg, inc_min, inc_hora, clr_seg, modo, parpadeo
    );
endinterface

// File: rtl/control_reloj.sv
// control_reloj
// Mode and timing controller for the 24-hour clock counter: one-second
// prescaler, button synchronizing/debouncing, RUN / SET_HORAS / SET_MIN
// mode machine with auto-repeat increments, and display blink.
// Ports:
//   clk    : system clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : control_reloj_if.slave (buttons in, pulses/mode/blink out)
// All outputs are registered.

// Per-button conditioning: 2-flop synchronizer then a level debouncer.
// The level follows the synchronized input only after it has differed for
// DEB_CYCLES consecutive cycles; any return to the old level restarts.
module control_reloj_deb #(
    parameter int DEB_CYCLES = 500_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level
);
    localparam int             DW       = $clog2(DEB_CYCLES + 1);
    localparam logic [DW-1:0]  CNT_LAST = DW'(DEB_CYCLES - 1);

    logic          sync1_q, sync1_d, sync2_q, sync2_d, lvl_q, lvl_d;
    logic [DW-1:0] cnt_q, cnt_d;

    always_comb begin
        sync1_d = raw;
        sync2_d = sync1_q;
        lvl_d   = lvl_q;
        cnt_d   = '0;
        if (sync2_q != lvl_q) begin
            if (cnt_q == CNT_LAST) lvl_d = sync2_q;
            else                   cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            lvl_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            lvl_q   <= lvl_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level = lvl_q;
endmodule

module control_reloj #(
    parameter int CLK_HZ     = 50_000_000,
    parameter int DEB_CYCLES = 500_000,
    parameter int REP_DELAY  = 25_000_000,
    parameter int REP_PERIOD = 6_250_000
) (
    input  logic             clk,
    input  logic             rst_n,
    control_reloj_if.slave   bus
);
    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_HORAS = 2'b01,
        ST_MIN   = 2'b10,
        ST_BAD   = 2'b11
    } mode_e;

    localparam int BLK_HALF = (CLK_HZ / 4 > 0) ? CLK_HZ / 4 : 1;
    localparam int PW       = $clog2(CLK_HZ + 1);
    localparam int BW       = $clog2(BLK_HALF + 1);
    localparam int RW       = $clog2(REP_DELAY + 1);
    localparam logic [PW-1:0] PRE_LAST   = PW'(CLK_HZ - 1);
    localparam logic [BW-1:0] BLK_LAST   = BW'(BLK_HALF - 1);
    localparam logic [RW-1:0] REP_LAST   = RW'(REP_DELAY);
    // After a repeat fires the counter reloads so the next one lands
    // REP_PERIOD cycles later at the same REP_LAST compare value.
    localparam logic [RW-1:0] REP_RELOAD = RW'(REP_DELAY - REP_PERIOD + 1);

    // index 0: btn_modo, index 1: btn_ajuste
    logic [1:0] btn_raw, btn_lvl, btn_press, lvl_prev_q, lvl_prev_d;

    assign btn_raw = {bus.btn_ajuste, bus.btn_modo};

    for (genvar i = 0; i < 2; i++) begin : g_deb
        control_reloj_deb #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
            .clk   (clk),
            .rst_n (rst_n),
            .raw   (btn_raw[i]),
            .level (btn_lvl[i])
        );
    end

    assign btn_press = btn_lvl & ~lvl_prev_q;

    mode_e         mode_q, mode_d;
    logic [PW-1:0] pre_q, pre_d;
    logic [BW-1:0] blk_cnt_q, blk_cnt_d;
    logic [RW-1:0] rep_cnt_q, rep_cnt_d;
    logic          blink_q, blink_d, rep_act_q, rep_act_d;
    logic          tick_q, tick_d, inc_min_q, inc_min_d;
    logic          inc_hora_q, inc_hora_d, clr_q, clr_d;
    logic          press_modo, press_aj, lvl_aj, in_set, rep_fire, adj_evt;

    always_comb begin
        lvl_prev_d = btn_lvl;
        press_modo = btn_press[0];
        press_aj   = btn_press[1];
        lvl_aj     = btn_lvl[1];
        in_set     = (mode_q == ST_HORAS) || (mode_q == ST_MIN);

        // Mode machine; the unused code falls back to RUN.
        mode_d = mode_q;
        case (mode_q)
            ST_RUN:   if (press_modo) mode_d = ST_HORAS;
            ST_HORAS: if (press_modo) mode_d = ST_MIN;
            ST_MIN:   if (press_modo) mode_d = ST_RUN;
            default:  mode_d = ST_RUN;
        endcase

        // Prescaler only runs in RUN and sits at 0 otherwise, so re-entering
        // RUN gives a full second before the first tick.
        pre_d  = '0;
        tick_d = 1'b0;
        if (mode_q == ST_RUN) begin
            if (pre_q == PRE_LAST) tick_d = 1'b1;
            else                   pre_d  = pre_q + 1'b1;
        end

        // Auto-repeat: armed by an adjust press, dropped on release, on any
        // mode change and outside the SET modes.
        rep_fire  = rep_act_q && lvl_aj && (rep_cnt_q == REP_LAST);
        rep_act_d = 1'b0;
        rep_cnt_d = '0;
        if (in_set && !press_modo && lvl_aj) begin
            if (press_aj) begin
                rep_act_d = 1'b1;
                rep_cnt_d = RW'(1);
            end else if (rep_act_q) begin
                rep_act_d = 1'b1;
                rep_cnt_d = (rep_cnt_q == REP_LAST) ? REP_RELOAD : rep_cnt_q + 1'b1;
            end
        end

        // A simultaneous mode press wins over an increment.
        adj_evt    = in_set && !press_modo && (press_aj || rep_fire);
        inc_hora_d = adj_evt && (mode_q == ST_HORAS);
        inc_min_d  = adj_evt && (mode_q == ST_MIN);
        clr_d      = press_modo && (mode_q == ST_MIN);

        // Blink restarts visible on every mode entry; steady on in RUN.
        blink_d   = 1'b1;
        blk_cnt_d = '0;
        if (in_set && (mode_d == mode_q)) begin
            blink_d = blink_q;
            if (blk_cnt_q == BLK_LAST) blink_d   = ~blink_q;
            else                       blk_cnt_d = blk_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lvl_prev_q <= '0;
            mode_q     <= ST_RUN;
            pre_q      <= '0;
            blk_cnt_q  <= '0;
            blink_q    <= 1'b1;
            rep_act_q  <= 1'b0;
            rep_cnt_q  <= '0;
            tick_q     <= 1'b0;
            inc_min_q  <= 1'b0;
            inc_hora_q <= 1'b0;
            clr_q      <= 1'b0;
        end else begin
            lvl_prev_q <= lvl_prev_d;
            mode_q     <= mode_d;
            pre_q      <= pre_d;
            blk_cnt_q  <= blk_cnt_d;
            blink_q    <= blink_d;
            rep_act_q  <= rep_act_d;
            rep_cnt_q  <= rep_cnt_d;
            tick_q     <= tick_d;
            inc_min_q  <= inc_min_d;
            inc_hora_q <= inc_hora_d;
            clr_q      <= clr_d;
        end
    end

    assign bus.tick_seg = tick_q;
    assign bus.inc_min  = inc_min_q;
    assign bus.inc_hora = inc_hora_q;
    assign bus.clr_seg  = clr_q;
    assign bus.modo     = mode_q;
    assign bus.parpadeo = blink_q;
endmodule

// File: doc/control_reloj.md
# control_reloj

Mode and timing controller for the 24-hour clock counter.
- Generates the one-second advance pulse from the system clock.
- Debounces two raw push-buttons.
- Runs a RUN / SET_HORAS / SET_MIN state machine that issues single-cycle increment pulses to the time counter, with auto-repeat while a button is held.
- Sits between the board buttons and the hours/minutes/seconds counter, and drives the display blink enable.

## Interface

Parameters:
- CLK_HZ, 50_000_000, system clock cycles per second; prescaler terminal count.
- DEB_CYCLES, 500_000, consecutive stable cycles required to accept a button level change.
- REP_DELAY, 25_000_000, held cycles after a press before auto-repeat starts.
- REP_PERIOD, 6_250_000, cycles between auto-repeat pulses.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- btn_modo  in  1  raw mode button, asynchronous, active-high.
- btn_ajuste  in  1  raw adjust button, asynchronous, active-high.
- tick_seg  out  1  one-cycle pulse: advance seconds.
- inc_min  out  1  one-cycle pulse: increment minutes.
- inc_hora  out  1  one-cycle pulse: increment hours.
- clr_seg  out  1  one-cycle pulse: clear seconds.
- modo  out  2  current mode: 00 RUN, 01 SET_HORAS, 10 SET_MIN.
- parpadeo  out  1  display blink enable; 1 means digits visible.

## Operation

- **Input conditioning:** each button passes through a 2-flop synchronizer, then a debouncer.
  - The debounced level changes only after the synchronized level differs from it for DEB_CYCLES consecutive cycles.
  - Any return to the old level clears the count.
  - A rising edge of the debounced level produces one press pulse per button.
- **Prescaler:** counts 0..CLK_HZ-1 in RUN only.
  - tick_seg is asserted on the cycle the count equals CLK_HZ-1; the count then wraps to 0.
  - In SET modes the count is held at 0.
- **Mode FSM:** a btn_modo press advances RUN -> SET_HORAS -> SET_MIN -> RUN.
  - The code 11 is unreachable; if it is ever entered, the FSM returns to RUN on the next cycle.
- **SET_HORAS / SET_MIN:** a btn_ajuste press emits inc_hora (SET_HORAS) or inc_min (SET_MIN) for one cycle.
- **Auto-repeat:** while debounced btn_ajuste stays high, one extra increment is emitted REP_DELAY cycles after the press pulse, then another every REP_PERIOD cycles. Release stops repeat immediately.
- **btn_ajuste in RUN:** ignored; no pulses.
- **Transition SET_MIN -> RUN:** clr_seg pulses for one cycle on the transition cycle. The prescaler restarts at 0, so the first tick_seg comes CLK_HZ cycles after entering RUN.
- **Blink:** in SET modes, parpadeo toggles every CLK_HZ/4 cycles, starting at 1 on mode entry. In RUN it is held at 1.
- **Simultaneous events:**
  - btn_modo press and btn_ajuste press (or repeat) on the same cycle: the mode change wins and the increment is dropped.
  - Prescaler terminal and btn_modo press on the same cycle in RUN: tick_seg is still emitted, then the mode changes.
  - A mode change cancels any auto-repeat in progress.
- **Pulse exclusivity:** tick_seg, inc_min and inc_hora are mutually exclusive.

## Timing

- All outputs are registered.
- Reset values: tick_seg=0, inc_min=0, inc_hora=0, clr_seg=0, modo=00, parpadeo=1. Prescaler, debouncers and repeat counters are cleared.
- Reset asserted mid-operation clears everything asynchronously; after release the block behaves as from power-up.
- **Button latency:** a raw level change stable from cycle 0 gives the press pulse at cycle DEB_CYCLES+2.
  - The output pulse (inc_*, or the modo update) appears one cycle later, at DEB_CYCLES+3.
- **Release:** takes the same DEB_CYCLES+2 to be recognized, so repeat stops at that point.
- **tick_seg period:** exactly CLK_HZ cycles in steady RUN.

## Test plan

Use a bench with CLK_HZ=16, DEB_CYCLES=4, REP_DELAY=8, REP_PERIOD=4.

1. **Reset, then RUN for 64 cycles:** modo=00, parpadeo=1, and tick_seg pulses exactly 4 times, 16 cycles apart, the first at cycle 16 after rst_n rises.
2. **Debounce:**
   - btn_modo glitches high for 3 cycles: modo stays 00.
   - btn_modo held high: modo=01 at cycle 7 after the edge; tick_seg stops; parpadeo toggles every 4 cycles.
3. **SET_HORAS adjust with repeat:** btn_ajuste held 30 cycles, then released.
   - inc_hora at cycle 7 after the edge, again at +8 and every +4 after that.
   - No inc_min and no tick_seg.
4. **Leaving SET_MIN:** press btn_modo twice more. modo goes 01->10->00, clr_seg pulses once on entering 00, and the first tick_seg comes 16 cycles later.
5. **Simultaneous presses:** btn_modo and btn_ajuste rise on the same cycle in SET_MIN: modo goes to 00 and no inc_min is emitted.
6. **Reset mid-repeat:** rst_n pulled low during auto-repeat in SET_MIN: all outputs go to reset values immediately, with no further inc_min after release.
